// File: rtl/inst_cache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package inst_cache_pkg;
  localparam int          ICACHE_LINE_BYTES = 16;
  localparam int          LINE_W            = ICACHE_LINE_BYTES * 8;
  localparam logic [31:0] ZERO_WORD         = 32'h0;

  typedef enum logic [1:0] {
    IC_IDLE = 2'd0,
    IC_REQ  = 2'd1,
    IC_WAIT = 2'd2
  } ic_state_e;

  function automatic logic [31:0] line_word(input logic [LINE_W-1:0] line, input logic [1:0] w);
    return line[32*w +: 32];
  endfunction
endpackage

// File: rtl/inst_cache_if.sv
// Fetch-side and refill-side signals of the instruction cache.
interface inst_cache_if;
  import inst_cache_pkg::*;
  logic              if_req;
  logic [31:0]       if_pc;
  logic [31:0]       if_inst;
  logic              if_inst_valid;
  logic              if_busy;
  logic              inst_re;
  logic [31:0]       inst_addr;
  logic [LINE_W-1:0] inst_data;
  logic              inst_busy;

  modport slave  (input  if_req, if_pc, inst_data, inst_busy,
                  output if_inst, if_inst_valid, if_busy, inst_re, inst_addr);
  modport master (output if_req, if_pc, inst_data, inst_busy,
                  input  if_inst, if_inst_valid, if_busy, inst_re, inst_addr);
endinterface

// File: rtl/inst_cache_array.sv
// Tag/valid/data storage: async read port, one write port, clear-all of valid bits.
module inst_cache_array
  import inst_cache_pkg::*;
#(
  parameter int INDEX_BITS = 4,
  parameter int TAG_BITS   = 28 - INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [LINE_W-1:0]     rd_line,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [LINE_W-1:0]     wr_line
);
  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]    valid;
  logic [TAG_BITS-1:0] tag_mem  [LINES];
  logic [LINE_W-1:0]   data_mem [LINES];

  // Only valid bits are reset; tag/data contents are don't-care until filled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   valid         <= '0;
    else if (clr) valid         <= '0;
    else if (we)  valid[wr_idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_line;
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_line  = data_mem[rd_idx];
endmodule

// File: rtl/inst_cache.sv
// Direct-mapped instruction cache: 1-cycle hits, 16-byte line refill via Memory_Ctrl handshake.
module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int INDEX_BITS = 4
) (
  input logic         clk,
  input logic         rst_n,
  input logic         rdy,
  input logic         flush,
  inst_cache_if.slave bus
);
  localparam int TAG_BITS = 28 - INDEX_BITS;

  ic_state_e           state, state_nxt;
  logic [31:0]         inst_q, inst_nxt, addr_q, addr_nxt;
  logic [31:2]         pc_q, pc_nxt;
  logic                valid_q, valid_nxt, busy_q, busy_nxt;
  logic                re_q, re_nxt, discard_q, discard_nxt;
  logic                clr, we, rd_valid, hit;
  logic [TAG_BITS-1:0] rd_tag;
  logic [LINE_W-1:0]   rd_line;
  logic                unused_pc_bits;

  assign unused_pc_bits = ^bus.if_pc[1:0];

  inst_cache_array #(.INDEX_BITS(INDEX_BITS), .TAG_BITS(TAG_BITS)) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr & rdy),
    .rd_idx  (bus.if_pc[4 +: INDEX_BITS]),
    .rd_valid(rd_valid),
    .rd_tag  (rd_tag),
    .rd_line (rd_line),
    .we      (we & rdy),
    .wr_idx  (pc_q[4 +: INDEX_BITS]),
    .wr_tag  (pc_q[31 -: TAG_BITS]),
    .wr_line (bus.inst_data)
  );

  assign hit = rd_valid && (rd_tag == bus.if_pc[31 -: TAG_BITS]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IC_IDLE;
      inst_q    <= ZERO_WORD;
      addr_q    <= ZERO_WORD;
      pc_q      <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      re_q      <= 1'b0;
      discard_q <= 1'b0;
    end else if (rdy) begin
      state     <= state_nxt;
      inst_q    <= inst_nxt;
      addr_q    <= addr_nxt;
      pc_q      <= pc_nxt;
      valid_q   <= valid_nxt;
      busy_q    <= busy_nxt;
      re_q      <= re_nxt;
      discard_q <= discard_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    inst_nxt    = inst_q;
    addr_nxt    = addr_q;
    pc_nxt      = pc_q;
    valid_nxt   = 1'b0;
    busy_nxt    = busy_q;
    re_nxt      = re_q;
    discard_nxt = discard_q;
    clr         = 1'b0;
    we          = 1'b0;
    case (state)
      IC_IDLE: begin
        // flush beats a same-cycle request, hit or miss
        if (flush) begin
          clr = 1'b1;
        end else if (bus.if_req) begin
          if (hit) begin
            inst_nxt  = line_word(rd_line, bus.if_pc[3:2]);
            valid_nxt = 1'b1;
          end else begin
            re_nxt      = 1'b1;
            addr_nxt    = {bus.if_pc[31:4], 4'h0};
            pc_nxt      = bus.if_pc[31:2];
            busy_nxt    = 1'b1;
            discard_nxt = 1'b0;
            state_nxt   = IC_REQ;
          end
        end
      end
      IC_REQ: begin
        if (flush) begin
          clr         = 1'b1;
          discard_nxt = 1'b1;
        end
        if (bus.inst_busy) begin
          re_nxt    = 1'b0;
          state_nxt = IC_WAIT;
        end
      end
      IC_WAIT: begin
        if (flush) begin
          clr         = 1'b1;
          discard_nxt = 1'b1;
        end
        // A flushed fill still finishes the handshake but is neither stored nor reported.
        if (!bus.inst_busy) begin
          busy_nxt  = 1'b0;
          state_nxt = IC_IDLE;
          if (!discard_q && !flush) begin
            we        = 1'b1;
            inst_nxt  = line_word(bus.inst_data, pc_q[3:2]);
            valid_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IC_IDLE;
    endcase
  end

  assign bus.if_inst       = inst_q;
  assign bus.if_inst_valid = valid_q;
  assign bus.if_busy       = busy_q;
  assign bus.inst_re       = re_q;
  assign bus.inst_addr     = addr_q;
endmodule

// File: tb/tb_inst_cache.sv
// Randomised scoreboard bench for inst_cache with a Memory_Ctrl timing model.
module tb_inst_cache;
  import inst_cache_pkg::*;

  logic clk = 1'b0, rst_n = 1'b0, rdy = 1'b1, flush = 1'b0;
  inst_cache_if bus();

  inst_cache #(.INDEX_BITS(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .rdy  (rdy),
    .flush(flush),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int stall_cfg = 0, accepts = 0, exp_refills = 0;
  logic [31:0] q[$];
  logic [31:0] mon_exp;
  logic rdy_edge = 1'b0;

  // Reference model: which line address each index currently holds.
  bit          mv[16];
  logic [27:0] mt[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] mbyte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h10;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] pc);
    logic [31:0] a;
    a = {pc[31:2], 2'b00};
    return {mbyte(a + 3), mbyte(a + 2), mbyte(a + 1), mbyte(a)};
  endfunction

  function automatic logic [LINE_W-1:0] ref_line(input logic [31:0] addr);
    logic [LINE_W-1:0] l;
    for (int k = 0; k < 16; k++) l[8*k +: 8] = mbyte(addr + k);
    return l;
  endfunction

  function automatic bit model_hit(input logic [31:0] pc);
    return mv[pc[7:4]] && (mt[pc[7:4]] == pc[31:4]);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mv[i] = 1'b0;
  endtask

  // Memory_Ctrl model: accept inst_re, stall, busy for 17 cycles, data final when busy falls.
  int mst = 0, mcnt = 0;
  logic [31:0] maddr = '0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.inst_busy <= 1'b0;
      bus.inst_data <= '0;
      mst           <= 0;
      mcnt          <= 0;
    end else begin
      case (mst)
        0: if (bus.inst_re) begin
          maddr   <= bus.inst_addr;
          mcnt    <= stall_cfg;
          mst     <= 1;
          accepts <= accepts + 1;
        end
        1: if (mcnt == 0) begin
          bus.inst_busy <= 1'b1;
          mcnt          <= 16;
          mst           <= 2;
        end else mcnt <= mcnt - 1;
        default: begin
          bus.inst_data <= {$urandom(), $urandom(), $urandom(), $urandom()};
          if (mcnt == 0) begin
            chk("inst_re_low_at_mem_done", 32'(bus.inst_re), 32'd0);
            bus.inst_busy <= 1'b0;
            bus.inst_data <= ref_line(maddr);
            mst           <= 0;
          end else mcnt <= mcnt - 1;
        end
      endcase
    end
  end

  always @(posedge clk) rdy_edge <= rdy;

  // Monitor: every fresh if_inst_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && rdy_edge && bus.if_inst_valid) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse actual=%h expected=no pulse", bus.if_inst);
      end else begin
        mon_exp = q.pop_front();
        chk("if_inst", bus.if_inst, mon_exp);
      end
    end
  end

  task automatic fetch(input logic [31:0] pc, input int flush_after);
    bit hit, flushed;
    int cyc, re_cyc;
    @(negedge clk);
    bus.if_req = 1'b1;
    bus.if_pc  = pc;
    hit = model_hit(pc);
    flushed = 1'b0;
    cyc = 0;
    re_cyc = 0;
    q.push_back(ref_word(pc));
    @(posedge clk); #1;
    chk("busy_on_accept", 32'(bus.if_busy), 32'(!hit));
    if (!hit) begin
      exp_refills++;
      chk("inst_addr", bus.inst_addr, {pc[31:4], 4'h0});
      while (bus.if_busy && cyc < 400) begin
        @(negedge clk);
        if (bus.inst_re) re_cyc++;
        if (flush_after != 0 && cyc == flush_after) begin
          flush = 1'b1;
          flushed = 1'b1;
          void'(q.pop_back());
          model_clear();
        end
        @(posedge clk); #1;
        flush = 1'b0;
        cyc++;
      end
      if (bus.if_busy) begin
        tests++;
        fails++;
        $display("FAIL miss_timeout actual=busy after %0d cycles expected=idle pc=%h", cyc, pc);
      end
      chk("inst_re_cycles", re_cyc, stall_cfg + 3);
      if (!flushed) begin
        mv[pc[7:4]] = 1'b1;
        mt[pc[7:4]] = pc[31:4];
      end
    end
  endtask

  task automatic flush_cycle(input bit with_req, input logic [31:0] pc);
    @(negedge clk);
    flush = 1'b1;
    bus.if_req = with_req;
    bus.if_pc = pc;
    @(posedge clk); #1;
    flush = 1'b0;
    model_clear();
    chk("flush_no_busy", 32'(bus.if_busy), 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_inst_re"}, 32'(bus.inst_re), 32'd0);
    chk({tag, "_valid"}, 32'(bus.if_inst_valid), 32'd0);
    chk({tag, "_busy"}, 32'(bus.if_busy), 32'd0);
    chk({tag, "_inst"}, bus.if_inst, 32'h0);
    chk({tag, "_addr"}, bus.inst_addr, 32'h0);
  endtask

  initial begin
    logic [31:0] snap, pc;
    int a0, r;
    bus.if_req = 1'b0;
    bus.if_pc  = '0;
    model_clear();
    #1 check_outputs_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Cold miss, then same-line hits back to back, then an index conflict.
    a0 = accepts;
    fetch(32'h0000_1008, 0);
    chk("cold_miss_word", ref_word(32'h1008), 32'h0B0A_0908);
    chk("one_inst_re", accepts - a0, 1);
    fetch(32'h0000_1000, 0);
    fetch(32'h0000_1004, 0);
    fetch(32'h0000_100C, 0);
    chk("hits_no_refill", accepts - a0, 1);
    fetch(32'h0000_1100, 0);
    fetch(32'h0000_1000, 0);

    // Stalled controller, flush in WAIT, flush in REQ, flush racing a request.
    stall_cfg = 5;
    fetch(32'h0000_2004, 0);
    fetch(32'h0000_3400, 2);
    stall_cfg = 0;
    fetch(32'h0000_3008, 10);
    fetch(32'h0000_3008, 0);
    flush_cycle(1'b1, 32'h0000_3008);
    fetch(32'h0000_3008, 0);

    // rdy low freezes the held pulse and ignores flush/requests.
    fetch(32'h0000_3008, 0);
    @(negedge clk);
    snap = bus.if_inst;
    rdy = 1'b0;
    flush = 1'b1;
    bus.if_req = 1'b1;
    bus.if_pc = 32'h0000_7000;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("frozen_valid", 32'(bus.if_inst_valid), 32'd1);
      chk("frozen_inst", bus.if_inst, snap);
      chk("frozen_busy", 32'(bus.if_busy), 32'd0);
    end
    @(negedge clk);
    rdy = 1'b1;
    flush = 1'b0;
    bus.if_req = 1'b0;
    @(posedge clk); #1;
    chk("valid_after_freeze", 32'(bus.if_inst_valid), 32'd0);
    fetch(32'h0000_3008, 0);

    // Reset in the middle of a refill.
    flush_cycle(1'b0, 32'h0);
    @(negedge clk);
    bus.if_req = 1'b1;
    bus.if_pc = 32'h0000_5000;
    exp_refills++;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1 check_outputs_zero("midwait_reset");
    q.delete();
    model_clear();
    bus.if_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fetch(32'h0000_5000, 0);

    // Random traffic over 3 tags x 16 indices.
    for (int it = 0; it < 200; it++) begin
      stall_cfg = $urandom_range(0, 3);
      pc = 32'h0000_4000 | ($urandom_range(0, 2) << 8) | ($urandom_range(0, 15) << 4)
         | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      r = $urandom_range(0, 19);
      if (r == 0) flush_cycle(1'b0, pc);
      else if (r == 1) fetch(pc, $urandom_range(1, 18));
      else if (r == 2) flush_cycle(1'b1, pc);
      else fetch(pc, 0);
    end

    @(negedge clk);
    bus.if_req = 1'b0;
    repeat (4) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    chk("refill_count", accepts, exp_refills);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
